// File: rtl/ex_multicycle_sched.sv
// Sequences multi-cycle EX units (mul/div, atomic, FPU) around the EX/MEM register.
// Issues one start pulse per op and stalls upstream until done, timeout or flush.
module ex_multicycle_sched #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_is_muldiv,
    input  logic             ex_is_atomic,
    input  logic             ex_is_fp_multi,
    input  logic             mem_busy,
    input  logic             flush,
    input  logic             muldiv_done,
    input  logic             atomic_done,
    input  logic             fpu_done,
    output logic             muldiv_start,
    output logic             atomic_start,
    output logic             fpu_start,
    output logic             unit_kill,
    output logic             ex_stall,
    output logic             hold_exmem,
    output logic             ex_result_valid,
    output logic [1:0]       ex_unit_sel,
    output logic             timeout_err,
    output logic [CNT_W-1:0] busy_cycles
);

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t      state;
    logic [1:0]  sel;
    logic [15:0] tmo_cnt;
    logic        req;
    logic [1:0]  req_sel;
    logic        sel_done;
    logic        tmo_hit;

    assign req     = ex_valid & (ex_is_muldiv | ex_is_atomic | ex_is_fp_multi);
    assign req_sel = ex_is_muldiv ? 2'b01 : (ex_is_atomic ? 2'b10 : 2'b11);
    assign tmo_hit = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

    // Only the done of the unit actually started is honoured.
    always_comb begin
        sel_done = 1'b0;
        case (sel)
            2'b01:   sel_done = muldiv_done;
            2'b10:   sel_done = atomic_done;
            2'b11:   sel_done = fpu_done;
            default: sel_done = 1'b0;
        endcase
    end

    always_comb begin
        muldiv_start    = 1'b0;
        atomic_start    = 1'b0;
        fpu_start       = 1'b0;
        unit_kill       = 1'b0;
        ex_stall        = 1'b0;
        ex_result_valid = 1'b0;
        hold_exmem      = mem_busy;
        ex_unit_sel     = sel;
        case (state)
            IDLE: begin
                if (req) begin
                    ex_stall = 1'b1;
                end else begin
                    ex_stall        = mem_busy;
                    ex_result_valid = ex_valid & ~flush;
                end
            end
            START: begin
                ex_stall     = 1'b1;
                muldiv_start = (sel == 2'b01) & ~flush;
                atomic_start = (sel == 2'b10) & ~flush;
                fpu_start    = (sel == 2'b11) & ~flush;
                unit_kill    = flush;
            end
            WAIT: begin
                ex_stall  = 1'b1;
                unit_kill = flush | (~sel_done & tmo_hit);
            end
            DONE: begin
                ex_stall        = mem_busy;
                ex_result_valid = ~mem_busy & ~flush;
            end
            default: ;
        endcase
        // Asynchronous reset silences every control output immediately.
        if (reset) begin
            muldiv_start    = 1'b0;
            atomic_start    = 1'b0;
            fpu_start       = 1'b0;
            unit_kill       = 1'b0;
            ex_stall        = 1'b0;
            ex_result_valid = 1'b0;
            hold_exmem      = 1'b0;
            ex_unit_sel     = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sel         <= 2'b00;
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
            busy_cycles <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req & ~flush & ~mem_busy) begin
                        sel   <= req_sel;
                        state <= START;
                    end
                end
                START: begin
                    tmo_cnt <= '0;
                    if (flush) begin
                        sel   <= 2'b00;
                        state <= IDLE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (busy_cycles != {CNT_W{1'b1}})
                        busy_cycles <= busy_cycles + 1'b1;
                    if (flush) begin
                        sel   <= 2'b00;
                        state <= IDLE;
                    end else if (sel_done) begin
                        state <= DONE;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        state       <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (flush | ~mem_busy) begin
                        sel   <= 2'b00;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
